// File: rtl/fp_add_result_buffer.sv
// Result FIFO behind the floating-point adder: buffers {result, exception, tag},
// optionally canonicalises NaNs on the way out and accumulates sticky flags.
module fp_add_result_buffer #(
    parameter int exp_width  = 8,
    parameter int frac_width = 23,
    parameter int depth      = 4,
    parameter int tag_width  = 4,
    parameter bit canon_nan  = 1'b1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [exp_width+frac_width:0]     in_result,
    input  logic [4:0]                        in_exception,
    input  logic [tag_width-1:0]              in_tag,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [exp_width+frac_width:0]     out_result,
    output logic [4:0]                        out_exception,
    output logic [tag_width-1:0]              out_tag,
    input  logic                              flags_clear,
    output logic [4:0]                        flags,
    output logic [$clog2(depth+1)-1:0]        count
);

    localparam int w  = exp_width + frac_width + 1;
    localparam int pw = $clog2(depth);
    localparam int cw = $clog2(depth + 1);
    localparam logic [cw-1:0] depth_c = cw'(depth);
    localparam logic [w-1:0] canon_value =
        {1'b0, {exp_width{1'b1}}, 1'b1, {(frac_width-1){1'b0}}};

    logic [w-1:0]         mem_result    [depth];
    logic [4:0]           mem_exception [depth];
    logic [tag_width-1:0] mem_tag       [depth];

    logic [pw-1:0] wr_ptr, rd_ptr;
    logic [cw-1:0] count_q;
    logic [4:0]    flags_q;
    logic          push, pop;
    logic [w-1:0]  head_result;
    logic          head_is_nan;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both
    // high. Both ready and valid depend only on the registered count, never on the
    // opposite side's handshake, so there is no combinational in_* -> out_* path.
    assign in_ready  = (count_q != depth_c);
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign count     = count_q;
    assign flags     = flags_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_result[wr_ptr]    <= in_result;
            mem_exception[wr_ptr] <= in_exception;
            mem_tag[wr_ptr]       <= in_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            flags_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + pw'(1);
            if (pop)  rd_ptr <= rd_ptr + pw'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + cw'(1);
                2'b01:   count_q <= count_q - cw'(1);
                default: count_q <= count_q;
            endcase
            // A clear wipes old history but the entry retiring this cycle still counts.
            if (pop)
                flags_q <= (flags_clear ? 5'b0 : flags_q) | out_exception;
            else if (flags_clear)
                flags_q <= '0;
        end
    end

    assign head_result = mem_result[rd_ptr];
    assign head_is_nan = (&head_result[w-2:frac_width]) && (|head_result[frac_width-1:0]);

    always_comb begin
        out_result    = '0;
        out_exception = '0;
        out_tag       = '0;
        if (out_valid) begin
            out_result    = (canon_nan && head_is_nan) ? canon_value : head_result;
            out_exception = mem_exception[rd_ptr];
            out_tag       = mem_tag[rd_ptr];
        end
    end

endmodule
